// File: rtl/axis_stream_fifo.sv
// AXI-Stream FIFO: circular buffer with first-word fall-through output and an optional
// store-and-forward mode that holds words back until a complete packet is stored.
module axis_stream_fifo #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned PACKET_MODE = 0
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]     s_axis_tkeep,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [$clog2(DEPTH):0]      occupancy,
    output logic [$clog2(DEPTH):0]      pkt_count
);

    localparam int unsigned KeepWidth  = DATA_WIDTH / 8;
    localparam int unsigned AddrWidth  = $clog2(DEPTH);
    localparam int unsigned CountWidth = AddrWidth + 1;
    localparam int unsigned EntryWidth = DATA_WIDTH + KeepWidth + 1;

    logic [EntryWidth-1:0] mem_q [DEPTH];
    logic [AddrWidth-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CountWidth-1:0] occupancy_q, occupancy_d;
    logic [CountWidth-1:0] pkt_count_q, pkt_count_d;
    logic                  release_q, release_d;

    logic [EntryWidth-1:0] rd_entry;
    logic                  push, pop, push_last, pop_last;
    logic                  full, not_empty, pkt_ready;

    assign rd_entry  = mem_q[rd_ptr_q];
    assign full      = (occupancy_q == CountWidth'(DEPTH));
    assign not_empty = (occupancy_q != '0);

    // Store-and-forward only presents data once a whole packet is in, or when an oversize
    // packet has filled the buffer and must be streamed out to avoid deadlock.
    assign pkt_ready = (PACKET_MODE == 0) || (pkt_count_q != '0) || release_q;

    assign s_axis_tready = aresetn && !full;
    assign m_axis_tvalid = aresetn && not_empty && pkt_ready;

    assign m_axis_tdata = rd_entry[EntryWidth-1 -: DATA_WIDTH];
    assign m_axis_tkeep = rd_entry[KeepWidth:1];
    assign m_axis_tlast = rd_entry[0];

    assign occupancy = occupancy_q;
    assign pkt_count = pkt_count_q;

    assign push      = s_axis_tvalid && s_axis_tready;
    assign pop       = m_axis_tvalid && m_axis_tready;
    assign push_last = push && s_axis_tlast;
    assign pop_last  = pop && rd_entry[0];

    always_comb begin
        occupancy_d = occupancy_q;
        unique case ({push, pop})
            2'b10:   occupancy_d = occupancy_q + CountWidth'(1);
            2'b01:   occupancy_d = occupancy_q - CountWidth'(1);
            default: occupancy_d = occupancy_q;
        endcase

        pkt_count_d = pkt_count_q;
        unique case ({push_last, pop_last})
            2'b10:   pkt_count_d = pkt_count_q + CountWidth'(1);
            2'b01:   pkt_count_d = pkt_count_q - CountWidth'(1);
            default: pkt_count_d = pkt_count_q;
        endcase

        release_d = release_q;
        if (pop_last) begin
            release_d = 1'b0;
        end else if ((PACKET_MODE != 0) && full && (pkt_count_q == '0)) begin
            release_d = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occupancy_q <= '0;
            pkt_count_q <= '0;
            release_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AddrWidth'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AddrWidth'(1);
            occupancy_q <= occupancy_d;
            pkt_count_q <= pkt_count_d;
            release_q   <= release_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define what is valid.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
        end
    end

endmodule
